// File: rtl/ff_rom_loader.sv
// ff_rom_loader: packs the hps_io byte stream into 16-bit words and writes
// them to a single-ported memory over a req/ack handshake. ioctl_wait holds
// off the HPS while a write is outstanding, and rom_ready is raised once the
// whole image has been written.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no download seen since reset
// S_LOAD  | download active, no write outstanding, bytes accepted
// S_WR    | first (or only) word of a byte event on the memory port
// S_WR2   | queued odd-byte word issued after a stale even byte
// S_FLUSH | download ended with an unpaired even byte; write it alone
// S_DONE  | image complete, rom_ready high
module ff_rom_loader #(
  parameter logic [7:0]  ROM_INDEX = 8'd0,
  parameter logic [24:0] ROM_BYTES = 25'h40000,
  parameter int          AW        = 24
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          ioctl_wait,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_din,
  output logic [1:0]    mem_be,
  output logic          mem_req,
  input  logic          mem_ack,
  output logic          rom_ready,
  output logic          overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WR,
    S_WR2,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t        r_state;
  logic          r_dl_prev;

  // even byte waiting for its odd partner
  logic          r_pend_valid;
  logic [7:0]    r_pend_byte;
  logic [AW-1:0] r_pend_waddr;

  // odd-byte word deferred behind a stale even byte
  logic          r_q_valid;
  logic [AW-1:0] r_q_addr;
  logic [15:0]   r_q_din;
  logic [1:0]    r_q_be;

  // one-cycle low gap on mem_req before WR2/FLUSH raise it again
  logic          r_arm;

  logic          r_wait;
  logic          r_req;
  logic [AW-1:0] r_addr;
  logic [15:0]   r_din;
  logic [1:0]    r_be;
  logic          r_ready;
  logic          r_ovf;

  logic          w_start;
  logic          w_in_range;
  logic          w_odd;
  logic [AW-1:0] w_waddr;
  logic          w_pend_match;
  logic          w_ack;
  logic          w_dl_end;
  logic          w_busy;
  logic          w_violation;

  assign w_start      = ioctl_download & ~r_dl_prev & (ioctl_index == ROM_INDEX);
  assign w_in_range   = (ioctl_addr < ROM_BYTES);
  assign w_odd        = ioctl_addr[0];
  assign w_waddr      = ioctl_addr[AW:1];
  assign w_pend_match = r_pend_valid & (r_pend_waddr == w_waddr);
  assign w_ack        = r_req & mem_ack;
  assign w_dl_end     = ~ioctl_download;
  assign w_busy       = (r_state == S_WR) || (r_state == S_WR2) || (r_state == S_FLUSH);
  // bytes arriving while idle or done are simply not ours to care about
  assign w_violation  = ioctl_wr & (w_busy | ((r_state == S_LOAD) & r_wait));

  // Loader FSM with registered memory-port and status outputs
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_dl_prev    <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_byte  <= 8'h00;
      r_pend_waddr <= '0;
      r_q_valid    <= 1'b0;
      r_q_addr     <= '0;
      r_q_din      <= 16'h0000;
      r_q_be       <= 2'b00;
      r_arm        <= 1'b0;
      r_wait       <= 1'b0;
      r_req        <= 1'b0;
      r_addr       <= '0;
      r_din        <= 16'h0000;
      r_be         <= 2'b00;
      r_ready      <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_dl_prev <= ioctl_download;
      if (w_start) begin
        // a fresh matching download abandons whatever was in flight
        r_state      <= S_LOAD;
        r_ready      <= 1'b0;
        r_ovf        <= 1'b0;
        r_pend_valid <= 1'b0;
        r_q_valid    <= 1'b0;
        r_arm        <= 1'b0;
        r_req        <= 1'b0;
        r_wait       <= 1'b0;
      end else begin
        if (w_violation) r_ovf <= 1'b1;
        case (r_state)
          S_IDLE: begin
          end

          S_LOAD: begin
            if (ioctl_wr && !r_wait) begin
              if (!w_in_range) begin
                r_ovf <= 1'b1;
              end else if (w_odd) begin
                r_state      <= S_WR;
                r_wait       <= 1'b1;
                r_req        <= 1'b1;
                r_pend_valid <= 1'b0;
                if (w_pend_match) begin
                  r_addr <= w_waddr;
                  r_din  <= {ioctl_dout, r_pend_byte};
                  r_be   <= 2'b11;
                end else if (r_pend_valid) begin
                  r_addr    <= r_pend_waddr;
                  r_din     <= {8'h00, r_pend_byte};
                  r_be      <= 2'b01;
                  r_q_valid <= 1'b1;
                  r_q_addr  <= w_waddr;
                  r_q_din   <= {ioctl_dout, 8'h00};
                  r_q_be    <= 2'b10;
                end else begin
                  r_addr <= w_waddr;
                  r_din  <= {ioctl_dout, 8'h00};
                  r_be   <= 2'b10;
                end
              end else begin
                r_pend_valid <= 1'b1;
                r_pend_byte  <= ioctl_dout;
                r_pend_waddr <= w_waddr;
                if (r_pend_valid) begin
                  r_state <= S_WR;
                  r_wait  <= 1'b1;
                  r_req   <= 1'b1;
                  r_addr  <= r_pend_waddr;
                  r_din   <= {8'h00, r_pend_byte};
                  r_be    <= 2'b01;
                end
              end
            end else if (w_dl_end) begin
              if (r_pend_valid) begin
                r_state <= S_FLUSH;
                r_wait  <= 1'b1;
                r_arm   <= 1'b1;
              end else begin
                r_state <= S_DONE;
                r_ready <= 1'b1;
              end
            end
          end

          S_WR: begin
            if (w_ack) begin
              r_req <= 1'b0;
              if (r_q_valid) begin
                r_state <= S_WR2;
                r_arm   <= 1'b1;
              end else if (w_dl_end && r_pend_valid) begin
                r_state <= S_FLUSH;
                r_arm   <= 1'b1;
              end else if (w_dl_end) begin
                r_state <= S_DONE;
                r_wait  <= 1'b0;
                r_ready <= 1'b1;
              end else begin
                r_state <= S_LOAD;
                r_wait  <= 1'b0;
              end
            end
          end

          S_WR2: begin
            if (r_arm) begin
              r_arm     <= 1'b0;
              r_req     <= 1'b1;
              r_addr    <= r_q_addr;
              r_din     <= r_q_din;
              r_be      <= r_q_be;
              r_q_valid <= 1'b0;
            end else if (w_ack) begin
              r_req <= 1'b0;
              if (w_dl_end && r_pend_valid) begin
                r_state <= S_FLUSH;
                r_arm   <= 1'b1;
              end else if (w_dl_end) begin
                r_state <= S_DONE;
                r_wait  <= 1'b0;
                r_ready <= 1'b1;
              end else begin
                r_state <= S_LOAD;
                r_wait  <= 1'b0;
              end
            end
          end

          S_FLUSH: begin
            if (r_arm) begin
              r_arm  <= 1'b0;
              r_req  <= 1'b1;
              r_addr <= r_pend_waddr;
              r_din  <= {8'h00, r_pend_byte};
              r_be   <= 2'b01;
            end else if (w_ack) begin
              r_req        <= 1'b0;
              r_pend_valid <= 1'b0;
              r_state      <= S_DONE;
              r_wait       <= 1'b0;
              r_ready      <= 1'b1;
            end
          end

          S_DONE: begin
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign ioctl_wait = r_wait;
  assign mem_req    = r_req;
  assign mem_addr   = r_addr;
  assign mem_din    = r_din;
  assign mem_be     = r_be;
  assign rom_ready  = r_ready;
  assign overflow   = r_ovf;

endmodule

// File: doc/ff_rom_loader.md
Name: ff_rom_loader

Overview:
- Sequences HPS ROM downloads into the game's program/graphics ROM store.
- Accepts the byte stream from hps_io (ioctl_*), packs it into 16-bit words and issues them to a single-ported memory write port (SDRAM controller or BRAM wrapper) over a req/ack handshake.
- Back-pressures the HPS through ioctl_wait while a write is outstanding.
- Reports rom_ready to the core reset logic once a complete image has landed.

Parameters:
ROM_INDEX, 8'd0, ioctl_index value that selects this loader; downloads with any other index are ignored
ROM_BYTES, 25'h40000, image size in bytes; writes at ioctl_addr >= ROM_BYTES are dropped
AW, 24, memory word-address width

Ports:
clk_sys  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
ioctl_download  in  1  high for the duration of an HPS download
ioctl_index  in  8  download target index
ioctl_wr  in  1  one-cycle byte strobe
ioctl_addr  in  25  byte address of ioctl_dout
ioctl_dout  in  8  download byte
ioctl_wait  out  1  registered; high while the loader cannot accept a byte
mem_addr  out  AW  word address (ioctl_addr[AW:1])
mem_din  out  16  write data; even byte in [7:0], odd byte in [15:8]
mem_be  out  2  byte enables; [0] covers even byte, [1] covers odd byte
mem_req  out  1  write request, level
mem_ack  in  1  memory accepted the write
rom_ready  out  1  image complete
overflow  out  1  sticky; set on an out-of-range or protocol-violating byte

Behaviour:
- Only one clock and one reset. The single clock is clk_sys. Reset is synchronous and active-high. Reset has priority in every state.
- Reset values: ioctl_wait=0, mem_req=0, mem_addr=0, mem_din=0, mem_be=0, rom_ready=0, overflow=0. Internal state: state=IDLE, pend_valid=0.
- Reset mid-transfer: mem_req drops on the next edge. No completion is awaited.
- Start condition: ioctl_download rising edge (registered compare) with ioctl_index==ROM_INDEX. This moves the FSM to LOAD and clears rom_ready, overflow and pend_valid.
- A rising edge with a different index leaves the state unchanged, including DONE.
- Pending-byte register holds pend_byte and pend_waddr.
- Byte handling. Each ioctl_wr accepted in LOAD is processed as follows:
  - ioctl_addr >= ROM_BYTES: byte dropped, overflow<=1.
  - Odd address, pend_valid, and pend_waddr==addr[24:1]: issue word {dout,pend_byte} with be=11. Clear pend_valid. Go to WR.
  - Odd address with no matching pending byte: if pend_valid, first issue the stale byte (be=01) and queue {dout,8'h00}, be=10, for WR2. Otherwise issue {dout,8'h00}, be=10, directly. Either way go to WR.
  - Even address: if pend_valid (stale), issue the stale byte (be=01) and go to WR. In both cases the new byte becomes pending (pend_valid=1).
- States:
  - IDLE: waits for the start condition.
  - LOAD: no write outstanding; ioctl_wait=0.
  - WR: mem_req=1 with mem_addr/mem_din/mem_be stable. On mem_ack=1, mem_req<=0. Next state is WR2 if a queued word exists; else FLUSH if download has ended with pend_valid; else DONE if download has ended; else LOAD.
  - WR2: issues the queued word with the same handshake as WR, then uses the same next-state rules minus WR2.
  - FLUSH: issues the pending byte (be=01), clears pend_valid, then goes to DONE.
  - DONE: rom_ready=1 until the next matching start or reset.
- ioctl_wait: registered, 1 in WR, WR2 and FLUSH, and 0 otherwise. It rises the cycle after the triggering ioctl_wr.
- Protocol violation: an ioctl_wr arriving while ioctl_wait=1 or state≠LOAD is ignored and sets overflow<=1. It is a protocol violation only when state≠IDLE/DONE.
- Handshake: mem_req lasts at least 1 cycle. mem_ack may be high in the first req cycle. After ack, mem_req is low for at least 1 cycle before the next request. mem_ack while mem_req=0 is ignored.
- Download end (ioctl_download falling) during WR/WR2: finish the write first, then FLUSH or DONE as above. Falling in LOAD: FLUSH if pend_valid, else DONE.
- Write count per image: ceil(bytes/2) for a sequential stream, with no extra writes.

Test Plan:
- Sequential 4-byte download, index 0, bytes 11,22,33,44 at addr 0..3, mem_ack 1 cycle after req → two writes: (0,16'h2211,11) and (1,16'h4433,11); rom_ready=1 two cycles after ioctl_download falls; overflow=0.
- Odd length 3 bytes AA,BB,CC → writes (0,BBAA,11) then (1,00CC,01) from FLUSH after download end; then DONE.
- mem_ack stalled 20 cycles → mem_req, addr, data and be held stable for all 20 cycles and ioctl_wait=1 throughout; an ioctl_wr injected in that window is ignored and sets overflow=1.
- Non-sequential: even byte 55 at addr 8, then odd byte 66 at addr 3 → (4,0055,01), then (1,6600,10) via WR2.
- Byte at addr ROM_BYTES → no mem_req, overflow=1. A download with index 1 during DONE → rom_ready stays 1.
- reset asserted while mem_req=1 → next edge mem_req=0, rom_ready=0, state IDLE; a new index-0 download then completes normally.
